// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: extracts register/opcode/immediate fields and
// the EXTOp format select, then holds results in a two-entry skid buffer for ID/EX.
module id_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [6:0]          out_funct7,
  output logic [4:0]          i_immediate_shift_amount,
  output logic [11:0]         i_immediate,
  output logic [11:0]         s_immediate,
  output logic [11:0]         b_immediate,
  output logic [19:0]         u_immediate,
  output logic [19:0]         j_immediate,
  output logic [5:0]          EXTOp,
  output logic                out_illegal
);

  // Every field is a fixed bit slice of the word, so the entry keeps the raw
  // instruction and the fields are sliced from the head register.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [5:0]          extop;
    logic                illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state;
  entry_t head, skid, dec;
  logic   accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_ready && (state != EMPTY);

  always_comb begin
    dec.pc      = in_pc;
    dec.instr   = in_instr;
    dec.extop   = 6'b000000;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec.extop = 6'b000010;
      7'b0100011:                         dec.extop = 6'b000001;
      7'b1100011:                         dec.extop = 6'b000100;
      7'b0110111, 7'b0010111:             dec.extop = 6'b000101;
      7'b1101111:                         dec.extop = 6'b000110;
      7'b0110011, 7'b0001111, 7'b1110011: dec.extop = 6'b000000;
      default:                            dec.illegal = 1'b1;
    endcase
  end

  // in_ready is registered as "next state is not FULL", so out_ready never
  // reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head  <= dec;
          state <= ONE;
        end
        ONE: begin
          if (accept && !pop) begin
            skid     <= dec;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (accept) begin
            head <= dec;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: if (pop) begin
          head     <= skid;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid                = (state != EMPTY);
  assign out_pc                   = head.pc;
  assign out_opcode               = head.instr[6:0];
  assign out_rd                   = head.instr[11:7];
  assign out_funct3               = head.instr[14:12];
  assign out_rs1                  = head.instr[19:15];
  assign out_rs2                  = head.instr[24:20];
  assign out_funct7               = head.instr[31:25];
  assign i_immediate_shift_amount = head.instr[24:20];
  assign i_immediate              = head.instr[31:20];
  assign s_immediate              = {head.instr[31:25], head.instr[11:7]};
  assign b_immediate              = {head.instr[31], head.instr[7], head.instr[30:25], head.instr[11:8]};
  assign u_immediate              = head.instr[31:12];
  assign j_immediate              = {head.instr[31], head.instr[19:12], head.instr[20], head.instr[30:21]};
  assign EXTOp                    = head.extop;
  assign out_illegal              = head.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed decode vectors, stall/flush/reset scenarios
// and a randomized run against a queue-based reference model.
module tb_id_decode_stage;
  localparam int PCW = 32;
  localparam int OW  = PCW + 120;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PCW-1:0]  in_pc, out_pc;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rd, out_rs1, out_rs2, i_immediate_shift_amount;
  logic [2:0]      out_funct3;
  logic [11:0]     i_immediate, s_immediate, b_immediate;
  logic [19:0]     u_immediate, j_immediate;
  logic [5:0]      EXTOp;
  logic            out_illegal;
  logic [OW-1:0]   obs;

  int n_checks, n_fail;
  logic [63:0] mq[$];  // model buffer: {pc, instr}, head at index 0

  id_decode_stage #(.PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .i_immediate_shift_amount(i_immediate_shift_amount),
    .i_immediate(i_immediate), .s_immediate(s_immediate), .b_immediate(b_immediate),
    .u_immediate(u_immediate), .j_immediate(j_immediate),
    .EXTOp(EXTOp), .out_illegal(out_illegal)
  );

  assign obs = {out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
                i_immediate_shift_amount, i_immediate, s_immediate, b_immediate,
                u_immediate, j_immediate, EXTOp, out_illegal};

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] exp_vec(input logic [63:0] e);
    logic [31:0] x;
    logic [5:0]  ext;
    logic        ill;
    x   = e[31:0];
    ext = 6'd0;
    ill = 1'b0;
    case (x[6:0])
      7'h03, 7'h13, 7'h67: ext = 6'd2;
      7'h23:               ext = 6'd1;
      7'h63:               ext = 6'd4;
      7'h37, 7'h17:        ext = 6'd5;
      7'h6F:               ext = 6'd6;
      7'h33, 7'h0F, 7'h73: ext = 6'd0;
      default:             ill = 1'b1;
    endcase
    return {e[63:32], x[6:0], x[11:7], x[14:12], x[19:15], x[24:20], x[31:25],
            x[24:20], x[31:20], {x[31:25], x[11:7]}, {x[31], x[7], x[30:25], x[11:8]},
            x[31:12], {x[31], x[19:12], x[20], x[30:21]}, ext, ill};
  endfunction

  // One clock: the model applies the rules to the inputs held across the edge,
  // then outputs are sampled 1 time unit later.
  task automatic step();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (mq.size() < 2);
    pp  = out_ready && (mq.size() > 0);
    if (rst || flush) mq.delete();
    else begin
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h40;
    repeat (2) step();
    n_checks++;
    if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, {OW{1'b0}}}) begin
      n_fail++; $display("FAIL reset: valid=%b ready=%b out=%h expected valid=0 ready=1 out=0", out_valid, in_ready, obs);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    offer(32'hFFF00093, 32'h100); step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, i_immediate, EXTOp, out_rd, out_rs1, out_illegal, out_pc} !==
        {1'b1, 12'hFFF, 6'b000010, 5'd1, 5'd0, 1'b0, 32'h100}) begin
      n_fail++; $display("FAIL addi: got v=%b imm=%h ext=%b rd=%0d rs1=%0d ill=%b pc=%h", out_valid, i_immediate, EXTOp, out_rd, out_rs1, out_illegal, out_pc);
    end
    step();
    offer(32'h123452B7, 32'h104); step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, u_immediate, EXTOp, out_rd} !== {1'b1, 20'h12345, 6'b000101, 5'd5}) begin
      n_fail++; $display("FAIL lui: got v=%b u=%h ext=%b rd=%0d expected 1 12345 000101 5", out_valid, u_immediate, EXTOp, out_rd);
    end
    step();
    offer(32'h008000EF, 32'h108); step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, j_immediate, EXTOp, out_rd} !== {1'b1, 20'h00004, 6'b000110, 5'd1}) begin
      n_fail++; $display("FAIL jal: got v=%b j=%h ext=%b rd=%0d expected 1 00004 000110 1", out_valid, j_immediate, EXTOp, out_rd);
    end
    step();
    offer(32'h0000007F, 32'h10C); step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_illegal, EXTOp} !== {1'b1, 1'b1, 6'b000000}) begin
      n_fail++; $display("FAIL illegal: got v=%b ill=%b ext=%b expected 1 1 000000", out_valid, out_illegal, EXTOp);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    offer(32'h0020A423, 32'h200); step();
    offer(32'hFE000EE3, 32'h204);
    n_checks++;
    if ({out_valid, s_immediate, EXTOp, out_rs1, out_rs2, in_ready} !== {1'b1, 12'h008, 6'b000001, 5'd1, 5'd2, 1'b1}) begin
      n_fail++; $display("FAIL sw: got v=%b s=%h ext=%b rs1=%0d rs2=%0d rdy=%b", out_valid, s_immediate, EXTOp, out_rs1, out_rs2, in_ready);
    end
    step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, b_immediate, EXTOp, out_pc} !== {1'b1, 12'hFFE, 6'b000100, 32'h204}) begin
      n_fail++; $display("FAIL beq_no_bubble: got v=%b b=%h ext=%b pc=%h expected 1 ffe 000100 204", out_valid, b_immediate, EXTOp, out_pc);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [63:0] a, b, c;
    a = {32'h300, 32'h00100093}; b = {32'h304, 32'h0020A423}; c = {32'h308, 32'h123452B7};
    out_ready = 1'b0;
    offer(a[31:0], a[63:32]); step();
    offer(b[31:0], b[63:32]); step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready_after_b: got %b expected 0", in_ready);
    end
    offer(c[31:0], c[63:32]);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, exp_vec(a)}) begin
        n_fail++; $display("FAIL stall_hold_%0d: v=%b rdy=%b out=%h expected A=%h", i, out_valid, in_ready, obs, exp_vec(a));
      end
    end
    out_ready = 1'b1; step();
    n_checks++;
    if ({out_valid, in_ready, obs} !== {1'b1, 1'b1, exp_vec(b)}) begin
      n_fail++; $display("FAIL stall_b: v=%b rdy=%b out=%h expected B=%h", out_valid, in_ready, obs, exp_vec(b));
    end
    step(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, obs} !== {1'b1, exp_vec(c)}) begin
      n_fail++; $display("FAIL stall_c: v=%b out=%h expected C=%h", out_valid, obs, exp_vec(c));
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_empty: out_valid=%b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h00100093, 32'h400); step();
    offer(32'h00200113, 32'h404); step();
    offer(32'h00300193, 32'h408); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_full: v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    // flush in ONE, where in_ready=1, must still drop the offered word
    offer(32'h00100093, 32'h410); step();
    offer(32'h00500293, 32'h414); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; step();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_drop: v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(32'hFFF00093, 32'h500); step();
    offer(32'h0020A423, 32'h504); step();
    offer(32'h008000EF, 32'h508); rst = 1'b1; flush = 1'b1; step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, {OW{1'b0}}}) begin
      n_fail++; $display("FAIL reset_mid: v=%b rdy=%b out=%h expected 0 1 0", out_valid, in_ready, obs);
    end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops[12];
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h00};
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      if ($urandom_range(0, 11) != 11) in_instr[6:0] = ops[$urandom_range(0, 10)];
      step();
      n_checks++;
      if ({out_valid, in_ready} !== {mq.size() != 0, mq.size() < 2}) begin
        n_fail++; $display("FAIL rand_hs_%0d: v=%b rdy=%b expected v=%b rdy=%b", i, out_valid, in_ready, mq.size() != 0, mq.size() < 2);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if (obs !== exp_vec(mq[0])) begin
          n_fail++; $display("FAIL rand_data_%0d: got %h expected %h", i, obs, exp_vec(mq[0]));
        end
      end
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; n_checks = 0; n_fail = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
